easyaxi_slv: RTL and testbench

EASYAXI_SLV -- requirements
Module: easyaxi_slv

---
 rtl/easyaxi_slv.sv | 225 ++++++++++++++++++++++
 tb/tb_easyaxi_slv.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/easyaxi_slv.sv
// AXI read-only slave: queues AR requests in order and returns the beat
// address as read data, with per-beat OKAY/SLVERR/DECERR response.
module easyaxi_slv #(
   parameter int unsigned OST_DEPTH   = 4,
   parameter int unsigned ADDR_LIMIT  = 'h100,
   parameter int unsigned AXI_ID_W    = 4,
   parameter int unsigned AXI_ADDR_W  = 32,
   parameter int unsigned AXI_DATA_W  = 32,
   parameter int unsigned AXI_LEN_W   = 8,
   parameter int unsigned AXI_SIZE_W  = 3,
   parameter int unsigned AXI_BURST_W = 2,
   parameter int unsigned AXI_RESP_W  = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   axi_slv_arvalid,
   output logic                   axi_slv_arready,
   input  logic [AXI_ID_W-1:0]    axi_slv_arid,
   input  logic [AXI_ADDR_W-1:0]  axi_slv_araddr,
   input  logic [AXI_LEN_W-1:0]   axi_slv_arlen,
   input  logic [AXI_SIZE_W-1:0]  axi_slv_arsize,
   input  logic [AXI_BURST_W-1:0] axi_slv_arburst,
   output logic                   axi_slv_rvalid,
   input  logic                   axi_slv_rready,
   output logic [AXI_ID_W-1:0]    axi_slv_rid,
   output logic [AXI_DATA_W-1:0]  axi_slv_rdata,
   output logic [AXI_RESP_W-1:0]  axi_slv_rresp,
   output logic                   axi_slv_rlast
);

   // state   | meaning
   // S_IDLE  | no burst in progress, waiting for a queued AR
   // S_BURST | returning beats of the loaded AR, rvalid high

   localparam int unsigned PW = $clog2(OST_DEPTH);
   localparam logic [PW:0]            CNT_FULL    = (PW+1)'(OST_DEPTH);
   localparam logic [AXI_ADDR_W-1:0]  LIMIT       = AXI_ADDR_W'(ADDR_LIMIT);
   localparam logic [AXI_BURST_W-1:0] BURST_FIXED = AXI_BURST_W'(0);
   localparam logic [AXI_BURST_W-1:0] BURST_INCR  = AXI_BURST_W'(1);
   localparam logic [AXI_BURST_W-1:0] BURST_WRAP  = AXI_BURST_W'(2);
   localparam logic [AXI_BURST_W-1:0] BURST_RSVD  = AXI_BURST_W'(3);
   localparam logic [AXI_RESP_W-1:0]  RESP_OKAY   = AXI_RESP_W'(0);
   localparam logic [AXI_RESP_W-1:0]  RESP_SLVERR = AXI_RESP_W'(2);
   localparam logic [AXI_RESP_W-1:0]  RESP_DECERR = AXI_RESP_W'(3);

   typedef struct packed {
      logic [AXI_ID_W-1:0]    id;
      logic [AXI_ADDR_W-1:0]  addr;
      logic [AXI_LEN_W-1:0]   len;
      logic [AXI_SIZE_W-1:0]  size;
      logic [AXI_BURST_W-1:0] burst;
   } ar_t;

   typedef enum logic {S_IDLE, S_BURST} state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   ar_t                    r_mem [OST_DEPTH];
   logic [PW-1:0]          r_wptr;
   logic [PW-1:0]          r_rptr;
   logic [PW:0]            r_cnt;
   logic                   r_ar_en;
   ar_t                    w_ar_in;
   ar_t                    w_head;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_rhs;
   logic                   w_last;
   logic                   w_head_err;

   logic [AXI_ID_W-1:0]    r_id;
   logic [AXI_ADDR_W-1:0]  r_addr;
   logic [AXI_LEN_W-1:0]   r_len;
   logic [AXI_SIZE_W-1:0]  r_size;
   logic [AXI_BURST_W-1:0] r_burst;
   logic [AXI_LEN_W-1:0]   r_beat;
   logic                   r_err;
   logic [AXI_ADDR_W-1:0]  w_step;
   logic [AXI_ADDR_W-1:0]  w_wlen;
   logic [AXI_ADDR_W-1:0]  w_addr_nxt;
   logic [AXI_RESP_W-1:0]  w_rresp;

   assign w_ar_in = '{id:    axi_slv_arid,
                      addr:  axi_slv_araddr,
                      len:   axi_slv_arlen,
                      size:  axi_slv_arsize,
                      burst: axi_slv_arburst};
   assign w_head  = r_mem[r_rptr];
   assign w_full  = (r_cnt == CNT_FULL);
   assign w_empty = (r_cnt == '0);

   // r_ar_en keeps arready low while in reset even though the FIFO is empty
   assign axi_slv_arready = r_ar_en & ~w_full;
   assign w_push          = axi_slv_arvalid & axi_slv_arready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ar_en <= 1'b0;
      end else begin
         r_ar_en <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= w_ar_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
            2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign axi_slv_rvalid = (r_state == S_BURST);
   assign w_last         = (r_beat == r_len);
   assign w_rhs          = axi_slv_rvalid & axi_slv_rready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = S_BURST;
            end
         end
         S_BURST: begin
            if (w_rhs && w_last) begin
               if (!w_empty) begin
                  w_pop = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // WRAP is only legal for 2, 4, 8 or 16 beats
   assign w_head_err = (w_head.burst == BURST_RSVD) ||
                       ((w_head.burst == BURST_WRAP) &&
                        !((w_head.len == AXI_LEN_W'(1)) || (w_head.len == AXI_LEN_W'(3)) ||
                          (w_head.len == AXI_LEN_W'(7)) || (w_head.len == AXI_LEN_W'(15))));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_id    <= '0;
         r_addr  <= '0;
         r_len   <= '0;
         r_size  <= '0;
         r_burst <= '0;
         r_beat  <= '0;
         r_err   <= 1'b0;
      end else if (w_pop) begin
         r_id    <= w_head.id;
         r_addr  <= w_head.addr;
         r_len   <= w_head.len;
         r_size  <= w_head.size;
         r_burst <= w_head.burst;
         r_beat  <= '0;
         r_err   <= w_head_err;
      end else if (w_rhs) begin
         r_beat  <= r_beat + AXI_LEN_W'(1);
         r_addr  <= w_addr_nxt;
      end
   end

   always_comb begin
      w_step     = AXI_ADDR_W'(1) << r_size;
      w_wlen     = (AXI_ADDR_W'(r_len) + AXI_ADDR_W'(1)) << r_size;
      w_addr_nxt = r_addr;
      case (r_burst)
         BURST_FIXED: w_addr_nxt = r_addr;
         BURST_WRAP:  w_addr_nxt = (r_addr & ~(w_wlen - AXI_ADDR_W'(1))) |
                                   ((r_addr + w_step) & (w_wlen - AXI_ADDR_W'(1)));
         BURST_INCR:  w_addr_nxt = (r_addr & ~(w_step - AXI_ADDR_W'(1))) + w_step;
         default:     w_addr_nxt = (r_addr & ~(w_step - AXI_ADDR_W'(1))) + w_step;
      endcase
   end

   always_comb begin
      w_rresp = RESP_OKAY;
      if (axi_slv_rvalid) begin
         if (r_err) begin
            w_rresp = RESP_SLVERR;
         end else if (r_addr >= LIMIT) begin
            w_rresp = RESP_DECERR;
         end
      end
   end

   assign axi_slv_rid   = r_id;
   assign axi_slv_rdata = AXI_DATA_W'(r_addr);
   assign axi_slv_rresp = w_rresp;
   assign axi_slv_rlast = axi_slv_rvalid & w_last;

endmodule

// File: tb/tb_easyaxi_slv.sv
// Directed bench for easyaxi_slv: ordering, address sequencing, responses,
// backpressure, queue full behaviour and reset during a burst.
module tb_easyaxi_slv;

   localparam int OST = 4;

   logic        clk;
   logic        rst_n;
   logic        arvalid;
   logic        arready;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        rvalid;
   logic        rready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;

   int total = 0;
   int bad   = 0;

   easyaxi_slv #(.OST_DEPTH(OST), .ADDR_LIMIT('h100)) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .axi_slv_arvalid (arvalid),
      .axi_slv_arready (arready),
      .axi_slv_arid    (arid),
      .axi_slv_araddr  (araddr),
      .axi_slv_arlen   (arlen),
      .axi_slv_arsize  (arsize),
      .axi_slv_arburst (arburst),
      .axi_slv_rvalid  (rvalid),
      .axi_slv_rready  (rready),
      .axi_slv_rid     (rid),
      .axi_slv_rdata   (rdata),
      .axi_slv_rresp   (rresp),
      .axi_slv_rlast   (rlast)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired got=running exp=finished");
      $fatal(1, "watchdog");
   end

   task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int n;
      n = 0;
      arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
      while (arready !== 1'b1 && n < 100) begin
         @(posedge clk); #1; n++;
      end
      total++;
      if (n >= 100) begin
         bad++; $display("FAIL ar_accept id=%0d got arready=%b exp=1", id, arready);
      end else begin
         @(posedge clk); #1;
      end
      arvalid = 1'b0;
   endtask

   task automatic wait_rvalid(input string tag);
      int n;
      n = 0;
      while (rvalid !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      total++;
      if (rvalid !== 1'b1) begin
         bad++; $display("FAIL %s rvalid_timeout got=%b exp=1", tag, rvalid);
      end
   endtask

   task automatic test_reset();
      #12;
      total++; if (arready !== 1'b0) begin bad++; $display("FAIL rst_arready got=%b exp=0", arready); end
      total++; if (rvalid !== 1'b0 || rlast !== 1'b0) begin bad++; $display("FAIL rst_rvalid_rlast got=%b%b exp=00", rvalid, rlast); end
      total++; if (rid !== 4'd0 || rdata !== 32'd0 || rresp !== 2'd0) begin
         bad++; $display("FAIL rst_payload got=%h/%h/%h exp=0/0/0", rid, rdata, rresp);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      total++; if (arready !== 1'b1) begin bad++; $display("FAIL rst_release_arready got=%b exp=1", arready); end
   endtask

   task automatic test_incr();
      rready = 1'b1;
      send_ar(4'd1, 32'h10, 8'd3, 3'd2, 2'b01);
      total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL incr_latency1 got=%b exp=0", rvalid); end
      @(posedge clk); #1;
      total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL incr_latency2 got=%b exp=1", rvalid); end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (rvalid !== 1'b1 || rdata !== 32'h10 + 32'(4*i) || rid !== 4'd1 || rresp !== 2'd0 || rlast !== (i == 3)) begin
            bad++; $display("FAIL incr_beat%0d got v=%b d=%h id=%h r=%h l=%b exp v=1 d=%h id=1 r=0 l=%b",
                            i, rvalid, rdata, rid, rresp, rlast, 32'h10 + 32'(4*i), (i == 3));
         end
         @(posedge clk); #1;
      end
      total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL incr_end got=%b exp=0", rvalid); end
   endtask

   task automatic test_len0();
      rready = 1'b1;
      send_ar(4'd9, 32'h40, 8'd0, 3'd2, 2'b01);
      wait_rvalid("len0");
      total++; if (rdata !== 32'h40 || rlast !== 1'b1 || rid !== 4'd9) begin
         bad++; $display("FAIL len0_beat got d=%h l=%b id=%h exp d=40 l=1 id=9", rdata, rlast, rid);
      end
      @(posedge clk); #1;
      total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL len0_end got=%b exp=0", rvalid); end
   endtask

   task automatic test_wrap_fixed();
      logic [31:0] exp_w [4];
      exp_w = '{32'h34, 32'h38, 32'h3C, 32'h30};
      rready = 1'b1;
      send_ar(4'd2, 32'h34, 8'd3, 3'd2, 2'b10);
      wait_rvalid("wrap");
      for (int i = 0; i < 4; i++) begin
         total++;
         if (rdata !== exp_w[i] || rlast !== (i == 3) || rresp !== 2'd0) begin
            bad++; $display("FAIL wrap_beat%0d got d=%h l=%b r=%h exp d=%h l=%b r=0", i, rdata, rlast, rresp, exp_w[i], (i == 3));
         end
         @(posedge clk); #1;
      end
      send_ar(4'd3, 32'h30, 8'd3, 3'd2, 2'b00);
      wait_rvalid("fixed");
      for (int i = 0; i < 4; i++) begin
         total++;
         if (rdata !== 32'h30 || rlast !== (i == 3) || rid !== 4'd3) begin
            bad++; $display("FAIL fixed_beat%0d got d=%h l=%b id=%h exp d=30 l=%b id=3", i, rdata, rlast, rid, (i == 3));
         end
         @(posedge clk); #1;
      end
      total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL fixed_end got=%b exp=0", rvalid); end
   endtask

   task automatic test_resp();
      logic [1:0]  exp_r [4];
      logic [31:0] exp_d [4];
      exp_r = '{2'd0, 2'd0, 2'd3, 2'd3};
      exp_d = '{32'hF8, 32'hFC, 32'h100, 32'h104};
      rready = 1'b1;
      send_ar(4'd4, 32'hF8, 8'd3, 3'd2, 2'b01);
      wait_rvalid("decerr");
      for (int i = 0; i < 4; i++) begin
         total++;
         if (rresp !== exp_r[i] || rdata !== exp_d[i]) begin
            bad++; $display("FAIL decerr_beat%0d got r=%h d=%h exp r=%h d=%h", i, rresp, rdata, exp_r[i], exp_d[i]);
         end
         @(posedge clk); #1;
      end
      send_ar(4'd5, 32'h20, 8'd1, 3'd2, 2'b11);
      wait_rvalid("rsvd");
      for (int i = 0; i < 2; i++) begin
         total++; if (rresp !== 2'd2 || rlast !== (i == 1)) begin
            bad++; $display("FAIL rsvd_beat%0d got r=%h l=%b exp r=2 l=%b", i, rresp, rlast, (i == 1));
         end
         @(posedge clk); #1;
      end
      send_ar(4'd6, 32'h20, 8'd2, 3'd2, 2'b10);
      wait_rvalid("badwrap");
      for (int i = 0; i < 3; i++) begin
         total++; if (rresp !== 2'd2) begin bad++; $display("FAIL badwrap_beat%0d got r=%h exp r=2", i, rresp); end
         @(posedge clk); #1;
      end
      send_ar(4'd7, 32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01);
      wait_rvalid("rollover");
      total++; if (rdata !== 32'hFFFF_FFFC || rresp !== 2'd3) begin
         bad++; $display("FAIL rollover_beat0 got d=%h r=%h exp d=fffffffc r=3", rdata, rresp);
      end
      @(posedge clk); #1;
      total++; if (rdata !== 32'h0 || rresp !== 2'd0 || rlast !== 1'b1) begin
         bad++; $display("FAIL rollover_beat1 got d=%h r=%h l=%b exp d=0 r=0 l=1", rdata, rresp, rlast);
      end
      @(posedge clk); #1;
      total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL resp_end got=%b exp=0", rvalid); end
   endtask

   task automatic test_back_to_back();
      logic acc;
      logic [31:0] exp_d;
      rready = 1'b0;
      send_ar(4'd0, 32'h80, 8'd1, 3'd2, 2'b01);
      wait_rvalid("b2b_head");
      for (int i = 1; i <= OST + 1; i++) begin
         arvalid = 1'b1; arid = 4'(i); araddr = 32'h80 + 32'(16*i); arlen = 8'd1; arsize = 3'd2; arburst = 2'b01;
         total++;
         if (arready !== (i <= OST)) begin
            bad++; $display("FAIL b2b_arready%0d got=%b exp=%b", i, arready, (i <= OST));
         end
         if (i <= OST) begin
            @(posedge clk); #1;
         end
      end
      rready = 1'b1;
      for (int j = 0; j < 2*(OST + 2); j++) begin
         exp_d = 32'h80 + 32'(16*(j/2)) + 32'(4*(j%2));
         total++;
         if (rvalid !== 1'b1 || rid !== 4'(j/2) || rdata !== exp_d || rlast !== 1'(j%2)) begin
            bad++; $display("FAIL b2b_beat%0d got v=%b id=%h d=%h l=%b exp v=1 id=%h d=%h l=%b",
                            j, rvalid, rid, rdata, rlast, 4'(j/2), exp_d, 1'(j%2));
         end
         acc = arvalid & arready;
         @(posedge clk); #1;
         if (acc) arvalid = 1'b0;
      end
      arvalid = 1'b0;
      total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", rvalid); end
   endtask

   task automatic test_random_stall();
      logic [7:0]  len;
      logic [31:0] base;
      logic [3:0]  id;
      logic        stalled;
      logic [31:0] p_d;
      logic [3:0]  p_id;
      logic        p_l;
      logic [1:0]  p_r;
      int          beats;
      int          cyc;
      for (int b = 0; b < 2; b++) begin
         len  = (b == 0) ? 8'd5 : 8'd2;
         base = (b == 0) ? 32'h20 : 32'h60;
         id   = (b == 0) ? 4'hA : 4'hB;
         rready = 1'b0;
         send_ar(id, base, len, 3'd2, 2'b01);
         beats = 0; cyc = 0; stalled = 1'b0;
         p_d = '0; p_id = '0; p_l = 1'b0; p_r = '0;
         while (beats <= int'(len) && cyc < 300) begin
            if (stalled) begin
               total++;
               if (rvalid !== 1'b1 || rdata !== p_d || rid !== p_id || rlast !== p_l || rresp !== p_r) begin
                  bad++; $display("FAIL stall_hold b%0d got v=%b d=%h id=%h l=%b exp v=1 d=%h id=%h l=%b",
                                  b, rvalid, rdata, rid, rlast, p_d, p_id, p_l);
               end
            end
            if (rvalid === 1'b1 && rready === 1'b1) begin
               total++;
               if (rdata !== base + 32'(4*beats) || rid !== id || rlast !== (beats == int'(len))) begin
                  bad++; $display("FAIL stall_beat b%0d.%0d got d=%h id=%h l=%b exp d=%h id=%h l=%b",
                                  b, beats, rdata, rid, rlast, base + 32'(4*beats), id, (beats == int'(len)));
               end
               beats++;
            end
            stalled = (rvalid === 1'b1) && (rready === 1'b0);
            p_d = rdata; p_id = rid; p_l = rlast; p_r = rresp;
            @(posedge clk); #1;
            cyc++;
            rready = 1'($urandom_range(0, 1));
         end
         total++;
         if (beats != int'(len) + 1 || rvalid !== 1'b0) begin
            bad++; $display("FAIL stall_count b%0d got beats=%0d v=%b exp beats=%0d v=0", b, beats, rvalid, int'(len) + 1);
         end
      end
      rready = 1'b1;
   endtask

   task automatic test_reset_mid_burst();
      rready = 1'b1;
      send_ar(4'd5, 32'h0, 8'd7, 3'd2, 2'b01);
      wait_rvalid("rstmid");
      @(posedge clk); #1;
      @(posedge clk); #1;
      total++; if (rdata !== 32'h8 || rvalid !== 1'b1) begin
         bad++; $display("FAIL rstmid_beat2 got d=%h v=%b exp d=8 v=1", rdata, rvalid);
      end
      rst_n = 1'b0;
      #1;
      total++; if (rvalid !== 1'b0 || arready !== 1'b0 || rlast !== 1'b0) begin
         bad++; $display("FAIL rstmid_async got v=%b ar=%b l=%b exp 0/0/0", rvalid, arready, rlast);
      end
      total++; if (rid !== 4'd0 || rdata !== 32'd0 || rresp !== 2'd0) begin
         bad++; $display("FAIL rstmid_payload got %h/%h/%h exp 0/0/0", rid, rdata, rresp);
      end
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      total++; if (arready !== 1'b1 || rvalid !== 1'b0) begin
         bad++; $display("FAIL rstmid_release got ar=%b v=%b exp ar=1 v=0", arready, rvalid);
      end
      for (int i = 0; i < 10; i++) begin
         total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL rstmid_nobeat%0d got=%b exp=0", i, rvalid); end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst_n = 1'b0; arvalid = 1'b0; rready = 1'b0;
      arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
      test_reset();
      test_incr();
      test_len0();
      test_wrap_fixed();
      test_resp();
      test_back_to_back();
      test_random_stall();
      test_reset_mid_burst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
